// File: rtl/greedysnake_pkg.sv
// Shared definitions for the greedy snake front-end and direction controller.
//
// Contents:
//   - key index constants (bit positions inside key_raw / key_level)
//   - per-channel debounce FSM state encoding
//   - direction encoding consumed by the downstream direction/step controller
//   - small helper mapping a key index to its direction
package greedysnake_pkg;

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned CNT_W      = 32;

  localparam int unsigned KEY_X_UP   = 0;
  localparam int unsigned KEY_X_DOWN = 1;
  localparam int unsigned KEY_Y_UP   = 2;
  localparam int unsigned KEY_Y_DOWN = 3;

  // Debounce channel state; values are fixed so debug taps read consistently.
  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StPressCnt   = 2'd1,
    StHeld       = 2'd2,
    StReleaseCnt = 2'd3
  } key_state_e;

  // Direction request as seen by the direction/step controller.
  typedef enum logic [1:0] {
    DirXUp   = 2'd0,
    DirXDown = 2'd1,
    DirYUp   = 2'd2,
    DirYDown = 2'd3
  } snake_dir_e;

  // Game mode shared with the controller.
  typedef enum logic [0:0] {
    ModeRun   = 1'b0,
    ModePause = 1'b1
  } snake_mode_e;

  function automatic snake_dir_e key_to_dir(input logic [1:0] key_idx);
    snake_dir_e dir;
    unique case (key_idx)
      2'd0:    dir = DirXUp;
      2'd1:    dir = DirXDown;
      2'd2:    dir = DirYUp;
      default: dir = DirYDown;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/greedysnake_key_filter.sv
// Single push-button channel: polarity normalisation, 2-FF synchroniser, and a
// debounce FSM that confirms a change only after DEBOUNCE_CNT+1 consecutive
// stable synchronised samples.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   key_raw  raw, unsynchronised button pin
//   pulse    one-cycle registered pulse on each confirmed press
//   level    debounced pressed level (1 = pressed)
module greedysnake_key_filter
  import greedysnake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT   = 32'd540_000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CNT - 1);

  // Normalised before the synchroniser so that reset value 0 means "released".
  logic press_raw;
  assign press_raw = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= press_raw;
      sync2_q <= sync1_q;
    end
  end

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             cnt_done;

  assign cnt_done = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sync2_q) begin
          state_d = StPressCnt;
          cnt_d   = '0;
        end
      end

      StPressCnt: begin
        if (!sync2_q) begin
          // Bounce before confirmation: drop the press silently.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = StHeld;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHeld: begin
        if (!sync2_q) begin
          state_d = StReleaseCnt;
          cnt_d   = '0;
        end
      end

      StReleaseCnt: begin
        if (sync2_q) begin
          // Release bounce absorbed; no new pulse for the same press.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = StIdle;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/greedysnake_key_debounce.sv
// Debounce front-end for the snake game's four direction buttons. Each button
// gets an independent filter channel; simultaneous presses each produce their
// own pulse with no priority applied here.
//
// Ports:
//   clk         system clock (27 MHz)
//   rst         asynchronous active-high reset
//   key_raw     raw button pins; [0]=x_up [1]=x_down [2]=y_up [3]=y_down
//   key_x_up    one-cycle press pulse, x_up
//   key_x_down  one-cycle press pulse, x_down
//   key_y_up    one-cycle press pulse, y_up
//   key_y_down  one-cycle press pulse, y_down
//   key_level   debounced pressed levels, same index order as key_raw
module greedysnake_key_debounce
  import greedysnake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT   = 32'd540_000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic                key_x_up,
  output logic                key_x_down,
  output logic                key_y_up,
  output logic                key_y_down,
  output logic [NUM_KEYS-1:0] key_level
);

  logic [NUM_KEYS-1:0] key_pulse;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    greedysnake_key_filter #(
      .DEBOUNCE_CNT   (DEBOUNCE_CNT),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_filter (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_raw[i]),
      .pulse   (key_pulse[i]),
      .level   (key_level[i])
    );
  end

  assign key_x_up   = key_pulse[KEY_X_UP];
  assign key_x_down = key_pulse[KEY_X_DOWN];
  assign key_y_up   = key_pulse[KEY_Y_UP];
  assign key_y_down = key_pulse[KEY_Y_DOWN];

endmodule

// File: tb/tb_greedysnake_key_debounce.sv
// Bench for greedysnake_key_debounce with DEBOUNCE_CNT = 4, active-low keys.
// Reference model: each key's raw press bit goes through a 2-sample delay, and
// the debounced level flips once the delayed input has differed from it for
// DEBOUNCE_CNT+1 consecutive samples; a flip to pressed emits one pulse.
module tb_greedysnake_key_debounce;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic       key_x_up, key_x_down, key_y_up, key_y_down;
  logic [3:0] key_level;
  logic [3:0] pulses;

  assign pulses = {key_y_down, key_y_up, key_x_down, key_x_up};

  always #5 clk = ~clk;

  greedysnake_key_debounce #(
    .DEBOUNCE_CNT   (D),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_x_up   (key_x_up),
    .key_x_down (key_x_down),
    .key_y_up   (key_y_up),
    .key_y_down (key_y_down),
    .key_level  (key_level)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] m_d1, m_d2, m_lvl, m_pulse;
  int         m_run [4];

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic s;
        s = m_d2[k];
        m_pulse[k] = 1'b0;
        if (s == m_lvl[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k]   = s;
            m_run[k]   = 0;
            m_pulse[k] = s;
          end
        end
        m_d2[k] = m_d1[k];
        m_d1[k] = ~key_raw[k];
      end
    end
  endtask

  // Drive at negedge, advance one posedge, return 1 time unit after it.
  task automatic step(input logic [3:0] raw, input logic r);
    @(negedge clk);
    key_raw = raw;
    rst     = r;
    if (r) model_reset();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(4'hF, 1'b1);
    step(4'b0000, 1'b1);
    total++;
    if (pulses !== 4'b0 || key_level !== 4'b0) begin
      bad++;
      $display("FAIL reset_state: got pulse=%b level=%b want pulse=0000 level=0000",
               pulses, key_level);
    end
    for (int i = 0; i < 10; i++) step(4'hF, 1'b0);
  endtask

  task automatic test_press_latency();
    int npulse;
    // Edge index 0 is where the press is first sampled.
    step(4'b1110, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(4'b1110, 1'b0);
      total++;
      if (pulses[0] !== (i == 6) || key_level[0] !== (i >= 6)) begin
        bad++;
        $display("FAIL press_latency edge+%0d: got pulse=%b level=%b want pulse=%b level=%b",
                 i, pulses[0], key_level[0], (i == 6), (i >= 6));
      end
    end
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      step(4'b1110, 1'b0);
      if (pulses !== 4'b0) npulse++;
    end
    total++;
    if (npulse !== 0 || key_level !== 4'b0001) begin
      bad++;
      $display("FAIL hold_no_repeat: got pulses=%0d level=%b want pulses=0 level=0001",
               npulse, key_level);
    end
  endtask

  task automatic test_release_bounce();
    int npulse;
    logic lvl_ok;
    npulse = 0;
    lvl_ok = 1'b1;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b1110, 1'b0);
      if (pulses !== 4'b0) npulse++;
      if (key_level[0] !== 1'b1) lvl_ok = 1'b0;
    end
    total++;
    if (npulse !== 0 || !lvl_ok) begin
      bad++;
      $display("FAIL release_bounce: got pulses=%0d level_held=%b want pulses=0 level_held=1",
               npulse, lvl_ok);
    end
    step(4'b1111, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(4'b1111, 1'b0);
      total++;
      if (pulses !== 4'b0 || key_level[0] !== (i < 6)) begin
        bad++;
        $display("FAIL clean_release edge+%0d: got pulse=%b level=%b want pulse=0000 level=%b",
                 i, pulses, key_level[0], (i < 6));
      end
    end
  endtask

  task automatic test_glitch();
    int npulse;
    logic lvl_ok;
    npulse = 0;
    lvl_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b1011, 1'b0);
      if (pulses !== 4'b0) npulse++;
      if (key_level !== 4'b0) lvl_ok = 1'b0;
    end
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 1'b0);
      if (pulses !== 4'b0) npulse++;
      if (key_level !== 4'b0) lvl_ok = 1'b0;
    end
    total++;
    if (npulse !== 0 || !lvl_ok) begin
      bad++;
      $display("FAIL glitch: got pulses=%0d level_clear=%b want pulses=0 level_clear=1",
               npulse, lvl_ok);
    end
  endtask

  task automatic test_simultaneous();
    step(4'b0101, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0101, 1'b0);
      total++;
      if (pulses !== ((i == 6) ? 4'b1010 : 4'b0000) ||
          key_level !== ((i >= 6) ? 4'b1010 : 4'b0000)) begin
        bad++;
        $display("FAIL simultaneous edge+%0d: got pulse=%b level=%b want pulse=%b level=%b",
                 i, pulses, key_level, (i == 6) ? 4'b1010 : 4'b0000,
                 (i >= 6) ? 4'b1010 : 4'b0000);
      end
    end
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0);
    total++;
    if (key_level !== 4'b0) begin
      bad++;
      $display("FAIL simultaneous_release: got level=%b want level=0000", key_level);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) step(4'b1110, 1'b0);
    total++;
    if (key_level !== 4'b0001) begin
      bad++;
      $display("FAIL async_reset_pre: got level=%b want level=0001", key_level);
    end
    // 1 unit after a posedge: no clock edge until the next negedge.
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (pulses !== 4'b0 || key_level !== 4'b0) begin
      bad++;
      $display("FAIL async_reset: got pulse=%b level=%b want pulse=0000 level=0000",
               pulses, key_level);
    end
    step(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0);
  endtask

  task automatic test_reset_held_key();
    int npulse;
    npulse = 0;
    // Press partially counted, then abandoned by reset.
    for (int i = 0; i < 5; i++) begin
      step(4'b0111, 1'b0);
      if (pulses !== 4'b0) npulse++;
    end
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b1);
    step(4'b0111, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step(4'b0111, 1'b0);
      if (pulses !== 4'b0) npulse++;
      total++;
      if (pulses[3] !== (i == 6)) begin
        bad++;
        $display("FAIL reset_held edge+%0d: got y_down=%b want y_down=%b",
                 i, pulses[3], (i == 6));
      end
    end
    total++;
    if (npulse !== 1) begin
      bad++;
      $display("FAIL reset_held_count: got pulses=%0d want pulses=1", npulse);
    end
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] raw;
    logic       r;
    int         nerr;
    raw  = 4'hF;
    nerr = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 6) == 0) raw[k] = ~raw[k];
      r = ($urandom_range(0, 799) == 0);
      step(raw, r);
      total++;
      if (pulses !== m_pulse || key_level !== m_lvl) begin
        bad++;
        nerr++;
        if (nerr <= 10)
          $display("FAIL random cyc%0d: got pulse=%b level=%b want pulse=%b level=%b",
                   i, pulses, key_level, m_pulse, m_lvl);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_latency();
    test_release_bounce();
    test_glitch();
    test_simultaneous();
    test_async_reset();
    test_reset_held_key();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/greedysnake_key_debounce.md
Name: greedysnake_key_debounce

Overview:
Front-end for the snake game's four direction buttons.
- Synchronises raw push-button inputs to the system clock and filters contact bounce.
- Emits exactly one single-cycle press pulse per confirmed press on key_x_up / key_x_down / key_y_up / key_y_down.
- Sits directly upstream of the direction/step controller, which consumes these pulses as its key inputs.
- Also exports the debounced key levels for the display/debug logic.

Parameters:
- DEBOUNCE_CNT, 32'd540_000, number of consecutive stable samples required to confirm a change (20 ms at 27 MHz); legal range ≥ 1.
- KEY_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  asynchronous active-high reset.
- key_raw  input  4  raw button pins, unsynchronised; index 0 = x_up, 1 = x_down, 2 = y_up, 3 = y_down.
- key_x_up  output  1  one-cycle press pulse, x_up.
- key_x_down  output  1  one-cycle press pulse, x_down.
- key_y_up  output  1  one-cycle press pulse, y_up.
- key_y_down  output  1  one-cycle press pulse, y_down.
- key_level  output  4  debounced pressed level per key (1 = pressed), same index order as key_raw.

Behaviour:
- Reset (async, active-high): all pulse outputs = 0, key_level = 4'b0000, both synchroniser stages = "released", all channel FSMs = IDLE, all counters = 0.
- Polarity: press = (key_raw[i] == ~KEY_ACTIVE_LOW). Polarity is applied before the synchroniser, so the synchroniser resets to "released".
- Synchroniser: 2-FF chain per key; FSMs only see sync2.
- Channels are fully independent; simultaneous presses on several keys each produce their own pulse, with no priority applied here.
- Per-channel FSM, 32-bit counter cnt:
  - IDLE (level = 0): sync2 pressed → PRESS_CNT, cnt ← 0.
  - PRESS_CNT: sync2 released → IDLE, cnt ← 0, no pulse. Else if cnt == DEBOUNCE_CNT-1 → HELD, level ← 1, pulse ← 1 for one cycle. Else cnt ← cnt+1.
  - HELD (level = 1): sync2 released → RELEASE_CNT, cnt ← 0.
  - RELEASE_CNT: sync2 pressed → HELD, cnt ← 0, no new pulse. Else if cnt == DEBOUNCE_CNT-1 → IDLE, level ← 0. Else cnt ← cnt+1.
- Pulse timing:
  - Pulse is a registered output, high for exactly one cycle, only on the PRESS_CNT → HELD transition.
  - Holding a key never repeats the pulse.
  - Releasing a key never produces a pulse.
- Latency: clean press first sampled at edge N (sync1 = 1) → pulse high in the cycle after edge N+2+DEBOUNCE_CNT. Release is symmetric: level falls after edge N+2+DEBOUNCE_CNT.
- Glitch rejection:
  - A press shorter than DEBOUNCE_CNT+1 synced samples gives no pulse and no level change.
  - A release bounce while HELD shorter than the same threshold is absorbed.
- Counter never wraps: it is bounded by DEBOUNCE_CNT-1 and cleared on every state entry.
- Reset mid-count: the channel abandons the count; no pulse is issued for the interrupted press.
- Key held through reset deassertion: treated as a new press, so one pulse follows after normal latency.
- DEBOUNCE_CNT = 1: the PRESS_CNT → HELD transition occurs on the first PRESS_CNT cycle.

Decomposition:
- Shared package greedysnake_pkg:
  - key index constants KEY_X_UP = 0, KEY_X_DOWN = 1, KEY_Y_UP = 2, KEY_Y_DOWN = 3.
  - 2-bit channel FSM state encoding IDLE = 0, PRESS_CNT = 1, HELD = 2, RELEASE_CNT = 3.
  - Forward/mode encodings shared with the downstream controller belong here too.
- One sub-module, greedysnake_key_filter: a single channel (synchroniser + FSM + counter), parameterised by DEBOUNCE_CNT and KEY_ACTIVE_LOW, with outputs pulse and level.
- The top instantiates four greedysnake_key_filter channels and maps their pulses to the named outputs.

Test Plan (DEBOUNCE_CNT = 4, KEY_ACTIVE_LOW = 1):
- Reset asserted mid-run → all pulses 0, key_level = 0 immediately (async), with no clk edge required.
- key_raw[0] driven 1 → 0 sampled at edge 10, held low → key_x_up = 1 only in the cycle after edge 16; key_level[0] = 1 from edge 16; no further pulses for 100 cycles held.
- key_raw[2] low for 3 cycles then high (glitch) → key_y_up never asserts, key_level[2] stays 0.
- key_x_up held, then released with 2-cycle release bounce, then held again → no second pulse, key_level[0] stays 1. Final clean release → level drops after edge N+6, no pulse.
- key_raw[1] and key_raw[3] pressed on the same edge → key_x_down and key_y_down pulse in the same cycle.
- key_raw[3] held low while rst pulses high for 3 cycles → after rst deassertion, exactly one key_y_down pulse at normal latency.
